// File: rtl/vx_decode_pkg.sv
// Shared helpers for the decode-to-issue flow control: credit counter width,
// warp-id width and the warp-to-issue-slot mapping.
package vx_decode_pkg;

  // Bits needed to hold a credit count in the range 0..ibuf_size.
  function automatic int calc_cw(input int ibuf_size);
    if (ibuf_size < 1) begin
      return 1;
    end
    return $clog2(ibuf_size + 1);
  endfunction

  // Width of a warp id; never narrower than one bit.
  function automatic int calc_nw_width(input int num_warps);
    if (num_warps > 1) begin
      return $clog2(num_warps);
    end
    return 1;
  endfunction

  // Width of an issue-slot index; never narrower than one bit.
  function automatic int calc_sw(input int issue_width);
    if (issue_width > 1) begin
      return $clog2(issue_width);
    end
    return 1;
  endfunction

  // Issue slot owning a warp: wid modulo the slot count (the low wid bits
  // for a power-of-two slot count); a single slot owns every warp.
  function automatic int unsigned wid_to_slot(input int unsigned wid,
                                              input int unsigned issue_width);
    if (issue_width <= 1) begin
      return 0;
    end
    return wid % issue_width;
  endfunction

endpackage

// File: rtl/vx_credit_counter.sv
// Credit counter for one issue slot. Starts full, counts down on dec and up
// on inc, and latches overflow_err if a return arrives while already full.
module vx_credit_counter
  import vx_decode_pkg::*;
#(
  parameter int MAX_CREDITS = 4,
  localparam int CW = calc_cw(MAX_CREDITS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          overflow_err
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX_CREDITS);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          err_reg;
  logic          err_next;

  // Next count: a simultaneous take and return cancel; a return while full
  // is dropped and flagged instead of wrapping. dec is only raised when the
  // count is non-zero, so the decrement cannot underflow.
  always_comb begin
    count_next = count_reg;
    err_next   = err_reg;
    if (dec && !inc) begin
      count_next = count_reg - ONE_C;
    end else if (inc && !dec) begin
      if (count_reg == MAX_C) begin
        err_next = 1'b1;
      end else begin
        count_next = count_reg + ONE_C;
      end
    end
  end

  // Counter and sticky error state; reset refills the slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= MAX_C;
      err_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      err_reg   <= err_next;
    end
  end

  assign count        = count_reg;
  assign overflow_err = err_reg;

endmodule

// File: rtl/vx_decode_credit_ctrl.sv
// Decode-side flow controller: one output register toward the per-slot
// instruction buffers plus one credit counter per issue slot. An instruction
// is taken only when its slot still has a free buffer entry; the entry is
// reserved at accept time, so the held instruction already owns its space.
module vx_decode_credit_ctrl
  import vx_decode_pkg::*;
#(
  parameter int ISSUE_WIDTH = 4,
  parameter int NUM_WARPS   = 16,
  parameter int IBUF_SIZE   = 4,
  parameter int DATAW       = 128,
  localparam int NW_WIDTH   = calc_nw_width(NUM_WARPS),
  localparam int CW         = calc_cw(IBUF_SIZE)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  input  logic [NW_WIDTH-1:0]       in_wid,
  input  logic [DATAW-1:0]          in_data,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [NW_WIDTH-1:0]       out_wid,
  output logic [DATAW-1:0]          out_data,
  input  logic                      out_ready,
  input  logic [ISSUE_WIDTH-1:0]    ibuf_pop,
  output logic [ISSUE_WIDTH*CW-1:0] credits,
  output logic                      credit_err
);

  localparam int SW = calc_sw(ISSUE_WIDTH);

  logic [SW-1:0]          slot_in;
  logic [CW-1:0]          credit_cnt [ISSUE_WIDTH];
  logic [ISSUE_WIDTH-1:0] dec_vec;
  logic [ISSUE_WIDTH-1:0] err_vec;
  logic                   credit_avail;
  logic                   out_free;
  logic                   accept;

  logic                   out_valid_reg;
  logic                   out_valid_next;
  logic [NW_WIDTH-1:0]    out_wid_reg;
  logic [NW_WIDTH-1:0]    out_wid_next;
  logic [DATAW-1:0]       out_data_reg;
  logic [DATAW-1:0]       out_data_next;

  assign slot_in = SW'(wid_to_slot(32'(in_wid), ISSUE_WIDTH));

  // Readiness depends only on register space and the target slot's credit,
  // never on in_valid, so the upstream stage can use it without a loop.
  assign credit_avail = (credit_cnt[slot_in] != '0);
  assign out_free     = !out_valid_reg || out_ready;
  assign in_ready     = out_free && credit_avail;
  assign accept       = in_valid && in_ready;

  // One credit counter per slot; the slot being written this cycle takes a
  // credit, the buffer's pop strobe gives one back.
  generate
    for (genvar gi = 0; gi < ISSUE_WIDTH; gi++) begin : g_slot
      assign dec_vec[gi] = accept && (slot_in == SW'(gi));

      vx_credit_counter #(
        .MAX_CREDITS (IBUF_SIZE)
      ) u_credit (
        .clk          (clk),
        .reset_n      (reset_n),
        .inc          (ibuf_pop[gi]),
        .dec          (dec_vec[gi]),
        .count        (credit_cnt[gi]),
        .overflow_err (err_vec[gi])
      );

      assign credits[gi*CW +: CW] = credit_cnt[gi];
    end
  endgenerate

  // Any slot's sticky overflow makes the whole block's error sticky.
  assign credit_err = |err_vec;

  // Output register next state: capture on accept (including the
  // pass-through case where the old value leaves the same cycle), drop valid
  // once the buffer takes it, otherwise hold.
  always_comb begin
    out_valid_next = out_valid_reg;
    out_wid_next   = out_wid_reg;
    out_data_next  = out_data_reg;
    if (accept) begin
      out_valid_next = 1'b1;
      out_wid_next   = in_wid;
      out_data_next  = in_data;
    end else if (out_ready) begin
      out_valid_next = 1'b0;
    end
  end

  // Output register; reset discards any held instruction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_reg <= 1'b0;
      out_wid_reg   <= '0;
      out_data_reg  <= '0;
    end else begin
      out_valid_reg <= out_valid_next;
      out_wid_reg   <= out_wid_next;
      out_data_reg  <= out_data_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_wid   = out_wid_reg;
  assign out_data  = out_data_reg;

endmodule

// File: tb/tb_vx_decode_credit_ctrl.sv
// Directed bench for vx_decode_credit_ctrl: an abstract model (integer
// credit pool per slot, one held-instruction slot) is checked against the
// DUT every falling edge, and literal expectations pin key scenarios.
module tb_vx_decode_credit_ctrl;

  localparam int IW = 4;
  localparam int NW = 4;
  localparam int IB = 4;
  localparam int DW = 128;
  localparam int CW = 3;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           in_valid = 1'b0;
  logic [NW-1:0]  in_wid = '0;
  logic [DW-1:0]  in_data = '0;
  logic           in_ready;
  logic           out_valid;
  logic [NW-1:0]  out_wid;
  logic [DW-1:0]  out_data;
  logic           out_ready = 1'b1;
  logic [IW-1:0]  ibuf_pop = '0;
  logic [IW*CW-1:0] credits;
  logic           credit_err;

  int asrt_cnt = 0;
  int fail_cnt = 0;
  bit chk_en = 1'b0;

  // Model state: free buffer entries per slot, sticky error, held instruction.
  int          m_credit [IW] = '{IB, IB, IB, IB};
  bit          m_err = 1'b0;
  bit          m_valid = 1'b0;
  logic [NW-1:0] m_wid = '0;
  logic [DW-1:0] m_data = '0;

  vx_decode_credit_ctrl #(
    .ISSUE_WIDTH (IW),
    .NUM_WARPS   (16),
    .IBUF_SIZE   (IB),
    .DATAW       (DW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_wid     (in_wid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_wid    (out_wid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .ibuf_pop   (ibuf_pop),
    .credits    (credits),
    .credit_err (credit_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    asrt_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cr(input int s);
    return int'(credits[s*CW +: CW]);
  endfunction

  // The decode side may hand over an instruction when the held one is gone
  // (or leaving now) and the target slot still has a free entry.
  function automatic bit model_ready();
    return (!m_valid || out_ready) && (m_credit[int'(in_wid) % IW] > 0);
  endfunction

  // Model advance per clock; reset refills every slot and empties the register.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < IW; s++) m_credit[s] = IB;
      m_err   = 1'b0;
      m_valid = 1'b0;
      m_wid   = '0;
      m_data  = '0;
    end else begin
      bit acc;
      acc = in_valid && model_ready();
      for (int s = 0; s < IW; s++) begin
        int taken;
        int given;
        taken = (acc && (int'(in_wid) % IW == s)) ? 1 : 0;
        given = ibuf_pop[s] ? 1 : 0;
        if (given == 1 && taken == 0 && m_credit[s] == IB) m_err = 1'b1;
        else m_credit[s] = m_credit[s] - taken + given;
      end
      if (acc) begin
        m_valid = 1'b1;
        m_wid   = in_wid;
        m_data  = in_data;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [IW*CW-1:0] exp_cr;
      for (int s = 0; s < IW; s++) exp_cr[s*CW +: CW] = CW'(m_credit[s]);
      chk("cyc_in_ready", in_ready, model_ready());
      chk("cyc_out_valid", out_valid, m_valid);
      chk("cyc_credits", credits, exp_cr);
      chk("cyc_credit_err", credit_err, m_err);
      if (m_valid) begin
        chk("cyc_out_wid", out_wid, m_wid);
        chk("cyc_out_data", out_data, m_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          v;
    logic [3:0]  wid;
    bit          rdy;
    logic [3:0]  pop;
  } vec_t;

  vec_t vecs [10] = '{
    '{1'b1, 4'd5, 1'b1, 4'b0000},
    '{1'b1, 4'd9, 1'b1, 4'b0000},
    '{1'b1, 4'd13, 1'b0, 4'b0010},
    '{1'b1, 4'd2, 1'b1, 4'b0000},
    '{1'b0, 4'd3, 1'b1, 4'b0110},
    '{1'b1, 4'd1, 1'b1, 4'b0010},
    '{1'b1, 4'd1, 1'b1, 4'b0000},
    '{1'b1, 4'd1, 1'b1, 4'b0000},
    '{1'b1, 4'd1, 1'b0, 4'b1000},
    '{1'b0, 4'd0, 1'b1, 4'b1111}
  };

  initial begin
    // Reset then idle.
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    chk_en = 1'b1;
    chk("rst_credits", credits, 12'h924);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_credit_err", credit_err, 1'b0);
    $display("reset/idle: credits=%03h out_valid=%0b", credits, out_valid);

    // Stream on warp 1 until slot 1 runs dry.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_wid = 4'd1; in_data = DW'(32'h100 + i);
      #1 chk("stream_ready", in_ready, 1'b1);
      tick();
      $display("stream accept %0d: out_data=%0h credit1=%0d", i, out_data, cr(1));
    end
    chk("stream_dry_ready", in_ready, 1'b0);
    chk("stream_credit1", cr(1), 0);
    chk("stream_credit0", cr(0), 4);
    chk("stream_credit3", cr(3), 4);
    tick();
    in_valid = 1'b0;
    chk("stream_5th_held_off", out_valid, 1'b0);

    // One credit back on slot 1 lets exactly one instruction through.
    ibuf_pop = 4'b0010;
    tick();
    ibuf_pop = 4'b0000;
    chk("pop_credit1", cr(1), 1);
    in_valid = 1'b1; in_wid = 4'd1; in_data = DW'(32'hAA);
    #1 chk("pop_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("pop_credit1_back0", cr(1), 0);
    chk("pop_out_data", out_data, DW'(32'hAA));
    $display("pop/accept: credit1=%0d out_data=%0h", cr(1), out_data);

    // Same-cycle take and return on slot 2.
    in_valid = 1'b1; in_wid = 4'd2; in_data = DW'(32'h1);
    tick();
    chk("slot2_after_one", cr(2), 3);
    in_wid = 4'd6; in_data = {64'hDEAD_0000_0000_0001, 64'hBEEF};
    ibuf_pop = 4'b0100;
    tick();
    ibuf_pop = 4'b0000;
    in_valid = 1'b0;
    chk("slot2_cancel", cr(2), 3);
    chk("slot2_out_wid", out_wid, 4'd6);
    chk("slot2_out_data", out_data, {64'hDEAD_0000_0000_0001, 64'hBEEF});
    $display("take+return slot2: credit2=%0d out_wid=%0d", cr(2), out_wid);

    // Back-pressure: output held for 5 cycles, then pass-through.
    in_valid = 1'b1; in_wid = 4'd3; in_data = DW'(32'h33);
    tick();
    out_ready = 1'b0;
    in_wid = 4'd7; in_data = DW'(32'h77);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_ready", in_ready, 1'b0);
      chk("stall_wid", out_wid, 4'd3);
      chk("stall_data", out_data, DW'(32'h33));
      $display("stall cycle %0d: out_wid=%0d out_data=%0h", i, out_wid, out_data);
    end
    out_ready = 1'b1;
    #1 chk("release_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("pass_wid", out_wid, 4'd7);
    chk("pass_data", out_data, DW'(32'h77));
    chk("pass_credit3", cr(3), 2);
    $display("pass-through: out_wid=%0d credit3=%0d", out_wid, cr(3));

    // Return on a full slot: counter holds, error sticks.
    ibuf_pop = 4'b0001;
    tick();
    ibuf_pop = 4'b0000;
    chk("ovf_credit0", cr(0), 4);
    chk("ovf_err", credit_err, 1'b1);
    tick();
    chk("ovf_err_sticky", credit_err, 1'b1);
    $display("overflow: credit0=%0d credit_err=%0b", cr(0), credit_err);

    // Asynchronous reset in the middle of a transfer.
    in_valid = 1'b1; in_wid = 4'd0; in_data = DW'(32'h55);
    tick();
    chk("pre_rst_valid", out_valid, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_out_wid", out_wid, 4'd0);
    chk("arst_out_data", out_data, DW'(0));
    chk("arst_credits", credits, 12'h924);
    chk("arst_err", credit_err, 1'b0);
    $display("async reset: credits=%03h credit_err=%0b", credits, credit_err);
    in_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    // Mixed directed vectors, checked by the per-cycle model comparison.
    for (int i = 0; i < 10; i++) begin
      in_valid  = vecs[i].v;
      in_wid    = vecs[i].wid;
      in_data   = DW'(32'hC000 + i);
      out_ready = vecs[i].rdy;
      ibuf_pop  = vecs[i].pop;
      tick();
      $display("vec %0d: out_valid=%0b out_wid=%0d credits=%03h err=%0b",
               i, out_valid, out_wid, credits, credit_err);
    end
    in_valid = 1'b0; ibuf_pop = '0; out_ready = 1'b1;
    tick();
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", asrt_cnt, fail_cnt);
    $finish;
  end

endmodule
